// File: rtl/uart_serial_core.sv
// UART serial core: baud tick generator, independent TX and RX engines.
module uart_serial_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OsLast  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OsHalf  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  tx_state_e             tx_state_q, tx_state_d;
  logic [OS_W-1:0]       tx_os_q, tx_os_d;
  logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_pen_q, tx_pen_d;
  logic                  tx_two_q, tx_two_d;
  logic                  tx_stop2_q, tx_stop2_d;
  logic                  txd_q, txd_d;
  logic                  tx_bit_end;

  logic                  rx_sync1_q, rx_sync2_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic [OS_W-1:0]       rx_os_q, rx_os_d;
  logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_pen_q, rx_pen_d;
  logic                  rx_podd_q, rx_podd_d;
  logic                  rx_pbit_q, rx_pbit_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ovr_q, rx_ovr_d;
  logic                  rx_mid, deliver;

  // Free-running baud tick divider.
  always_comb begin
    tick      = (div_cnt_q >= baud_div);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // TX next-state: bits are shifted out LSB first from the frame latched at accept.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_two_d   = tx_two_q;
    tx_stop2_d = tx_stop2_q;
    tx_ready   = 1'b0;
    tx_bit_end = tick && (tx_os_q == OsLast);
    if (tx_state_q != TxIdle && tick) tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ parity_odd;
          tx_pen_d   = parity_en;
          tx_two_d   = two_stop;
          tx_os_d    = '0;
          tx_bit_d   = '0;
          tx_stop2_d = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: if (tx_bit_end) tx_state_d = TxData;
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LastBit) tx_state_d = tx_pen_q ? TxParity : TxStop;
          else                     tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TxParity: if (tx_bit_end) tx_state_d = TxStop;
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_two_q && !tx_stop2_q) tx_stop2_d = 1'b1;
          else                         tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // txd is registered from the next state so the line never glitches.
    unique case (tx_state_d)
      TxStart:  txd_d = 1'b0;
      TxData:   txd_d = tx_shift_d[0];
      TxParity: txd_d = tx_par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // RX next-state: start-bit centre found at half a bit, then one sample per bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pen_d   = rx_pen_q;
    rx_podd_d  = rx_podd_q;
    rx_pbit_d  = rx_pbit_q;
    deliver    = 1'b0;
    rx_mid     = tick && (rx_os_q == ((rx_state_q == RxStart) ? OsHalf : OsLast));
    if (rx_state_q != RxIdle && rx_state_q != RxWaitHigh && tick) begin
      rx_os_d = rx_mid ? '0 : rx_os_q + 1'b1;
    end
    unique case (rx_state_q)
      RxIdle: begin
        rx_os_d  = '0;
        rx_bit_d = '0;
        if (!rx_sync2_q) begin
          rx_pen_d   = parity_en;
          rx_podd_d  = parity_odd;
          rx_state_d = RxStart;
        end
      end
      RxStart: if (rx_mid) rx_state_d = rx_sync2_q ? RxIdle : RxData;
      RxData: begin
        if (rx_mid) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LastBit) rx_state_d = rx_pen_q ? RxParity : RxStop;
          else                     rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RxParity: begin
        if (rx_mid) begin
          rx_pbit_d  = rx_sync2_q;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_mid) begin
          deliver    = 1'b1;
          rx_state_d = rx_sync2_q ? RxIdle : RxWaitHigh;
        end
      end
      RxWaitHigh: if (rx_sync2_q) rx_state_d = RxIdle;
      default:    rx_state_d = RxIdle;
    endcase
  end

  // RX output holding register with consume/overrun handling.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = rx_ferr_q;
    rx_perr_d  = rx_perr_q;
    rx_ovr_d   = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_ferr_d  = !rx_sync2_q;
        rx_perr_d  = rx_pen_q && (((^rx_shift_q) ^ rx_podd_q) != rx_pbit_q);
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  // All state registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      div_cnt_q  <= '0;
      tx_state_q <= TxIdle;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      txd_q      <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_state_q <= RxIdle;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pen_q   <= 1'b0;
      rx_podd_q  <= 1'b0;
      rx_pbit_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_two_q   <= tx_two_d;
      tx_stop2_q <= tx_stop2_d;
      txd_q      <= txd_d;
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pen_q   <= rx_pen_d;
      rx_podd_q  <= rx_podd_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign txd           = txd_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_serial_core.sv
// Scoreboard bench for uart_serial_core: TX line monitor, RX handshake monitor.
module tb_uart_serial_core;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [DW-1:0] baud_div = '0;
  logic          parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, txd;
  logic          rxd;
  logic          rxd_drv = 1'b1, loop_en = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_ready = 1'b1;
  logic          rx_frame_err, rx_parity_err, rx_overrun;
  logic          tx_mon_en = 1'b1;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_serial_core #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { logic [7:0] data; logic ferr; logic perr; } rx_exp_t;
  typedef struct { logic [15:0] bits; int n; } tx_exp_t;
  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];

  int n_cmp = 0, n_err = 0;
  int ov_cycles = 0, ov_pulses = 0;
  logic ov_prev = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic par_of(logic [7:0] d, logic odd);
    return logic'($countones(d) % 2) ^ odd;
  endfunction

  function automatic rx_exp_t mk_rx(logic [7:0] d, logic fe, logic pe);
    rx_exp_t e;
    e.data = d; e.ferr = fe; e.perr = pe;
    return e;
  endfunction

  // Expected line levels of a whole frame, one entry per bit time.
  function automatic tx_exp_t tx_frame(logic [7:0] d, logic pen, logic podd, logic two);
    tx_exp_t e;
    e.bits = '0;
    e.bits[0] = 1'b0;
    e.n = 1;
    for (int i = 0; i < DB; i++) begin e.bits[e.n] = d[i]; e.n++; end
    if (pen) begin e.bits[e.n] = par_of(d, podd); e.n++; end
    e.bits[e.n] = 1'b1; e.n++;
    if (two) begin e.bits[e.n] = 1'b1; e.n++; end
    return e;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // TX monitor: finds start edges on txd and samples each bit centre.
  initial begin : tx_mon
    logic prev;
    int bitp, k;
    tx_exp_t e;
    logic [15:0] got;
    prev = 1'b1;
    forever begin
      @(negedge PCLK);
      if (PRESETn && prev && !txd) begin
        if (!tx_mon_en || tx_q.size() == 0) begin
          if (tx_mon_en) begin
            n_cmp++; n_err++;
            $display("FAIL tx_unexpected: got a start bit, want idle line (t=%0t)", $time);
          end
          k = 0;
          while (!tx_ready && k < 5000) begin @(negedge PCLK); k++; end
        end else begin
          e = tx_q.pop_front();
          bitp = OS * (int'(baud_div) + 1);
          got = '0;
          repeat (bitp / 2) @(negedge PCLK);
          got[0] = txd;
          for (int i = 1; i < e.n; i++) begin
            repeat (bitp) @(negedge PCLK);
            got[i] = txd;
          end
          check("tx_frame_bits", 32'(got), 32'(e.bits));
        end
      end
      prev = txd;
    end
  end

  // RX monitor: compares each consumed frame against the scoreboard.
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && rx_valid && rx_ready) begin
        if (rx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_unexpected: got frame 0x%0h, want none (t=%0t)", rx_data, $time);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
          check("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
        end
      end
    end
  end

  // Overrun pulse counter.
  always @(negedge PCLK) begin
    if (rx_overrun) ov_cycles++;
    if (rx_overrun && !ov_prev) ov_pulses++;
    ov_prev = rx_overrun;
  end

  task automatic send_tx(logic [7:0] d, logic pen, logic podd, logic two, logic expect_it);
    int k;
    k = 0;
    while (!tx_ready && k < 10000) begin cyc(1); k++; end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data = d; parity_en = pen; parity_odd = podd; two_stop = two; tx_valid = 1'b1;
    if (expect_it) begin
      tx_q.push_back(tx_frame(d, pen, podd, two));
      if (loop_en) rx_q.push_back(mk_rx(d, 1'b0, 1'b0));
    end
    cyc(1);
    tx_valid = 1'b0;
  endtask

  // Drives one frame on rxd at baud_div=0; stop forced low keeps the line low a while.
  task automatic drive_rx(logic [7:0] d, logic pen, logic podd, logic bad_par, logic bad_stop);
    parity_en = pen; parity_odd = podd;
    rxd_drv = 1'b0; cyc(OS);
    for (int i = 0; i < DB; i++) begin rxd_drv = d[i]; cyc(OS); end
    if (pen) begin rxd_drv = par_of(d, podd) ^ bad_par; cyc(OS); end
    rxd_drv = !bad_stop; cyc(OS);
    if (bad_stop) cyc(5 * OS);
    rxd_drv = 1'b1; cyc(2 * OS);
  endtask

  initial begin : main
    int lo, vcnt;
    logic [7:0] d;
    logic pen, podd, two;

    cyc(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_parity_err", 32'(rx_parity_err), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    PRESETn = 1'b1;
    cyc(5);

    // 0xA5, no parity, looped back; busy time is ten bit times.
    loop_en = 1'b1;
    send_tx(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    lo = 0;
    while (!tx_ready && lo < 1000) begin cyc(1); lo++; end
    check("tx_busy_cycles", 32'(lo), 32'd160);
    cyc(40);

    // Odd parity loopback.
    send_tx(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(200);

    // Random frames, back-to-back, config scrambled mid-frame.
    for (int i = 0; i < 12; i++) begin
      while (!tx_ready) cyc(1);
      baud_div = DW'($urandom_range(0, 2));
      d = 8'($urandom); pen = 1'($urandom); podd = 1'($urandom); two = 1'($urandom);
      send_tx(d, pen, podd, two, 1'b1);
      cyc(30);
      tx_data = 8'($urandom); parity_en = 1'($urandom);
      parity_odd = 1'($urandom); two_stop = 1'($urandom);
    end
    while (!tx_ready) cyc(1);
    cyc(100);
    baud_div = '0;
    loop_en = 1'b0;
    cyc(20);

    // Short low pulse is rejected; a following frame is still received.
    rxd_drv = 1'b0; cyc(4); rxd_drv = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 100; i++) begin cyc(1); if (rx_valid) vcnt++; end
    check("glitch_no_valid", 32'(vcnt), 32'd0);
    rx_q.push_back(mk_rx(8'h5A, 1'b0, 1'b0));
    drive_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop bit forced low; line held low afterwards must not start a new frame.
    rx_q.push_back(mk_rx(8'h55, 1'b1, 1'b0));
    drive_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    rx_q.push_back(mk_rx(8'hC3, 1'b0, 1'b0));
    drive_rx(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Two frames unread: second dropped with a single overrun pulse.
    rx_ready = 1'b0;
    ov_cycles = 0; ov_pulses = 0;
    rx_q.push_back(mk_rx(8'h11, 1'b0, 1'b0));
    drive_rx(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_rx(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(10);
    check("overrun_pulses", 32'(ov_pulses), 32'd1);
    check("overrun_cycles", 32'(ov_cycles), 32'd1);
    check("held_rx_valid", 32'(rx_valid), 32'd1);
    check("held_rx_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    cyc(5);

    // Corrupted parity and a good odd-parity frame.
    rx_q.push_back(mk_rx(8'h6B, 1'b0, 1'b1));
    drive_rx(8'h6B, 1'b1, 1'b0, 1'b1, 1'b0);
    rx_q.push_back(mk_rx(8'h80, 1'b0, 1'b0));
    drive_rx(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a looped frame.
    loop_en = 1'b1;
    tx_mon_en = 1'b0;
    send_tx(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(60);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_rst_txd", 32'(txd), 32'd1);
    check("async_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("async_rst_rx_valid", 32'(rx_valid), 32'd0);
    cyc(3);
    PRESETn = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 400; i++) begin cyc(1); if (rx_valid) vcnt++; end
    check("no_rx_after_reset", 32'(vcnt), 32'd0);
    tx_mon_en = 1'b1;
    cyc(20);

    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time limit.
  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got timeout, want completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_serial_core.md
UART_SERIAL_CORE -- requirements
Module: uart_serial_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit (even, legal range 4..32).
REQ-003 SHALL have parameter DIV_W, default 16, meaning width of the baud divisor.
REQ-004 SHALL have ports, in order: PCLK  in  1  sole clock, all logic on rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 baud_div  in  DIV_W  tick period minus one, in PCLK cycles.
REQ-007 parity_en  in  1  add/check parity bit.
REQ-008 parity_odd  in  1  1 = odd parity, 0 = even parity.
REQ-009 two_stop  in  1  transmit two stop bits.
REQ-010 tx_data  in  DATA_BITS  byte to send.
REQ-011 tx_valid  in  1  tx_data valid.
REQ-012 tx_ready  out  1  transmitter idle, can accept.
REQ-013 txd  out  1  serial output, idle high.
REQ-014 rxd  in  1  asynchronous serial input.
REQ-015 rx_data  out  DATA_BITS  last received payload.
REQ-016 rx_valid  out  1  rx_data holds an unread frame.
REQ-017 rx_ready  in  1  consumer accepts rx_data.
REQ-018 rx_frame_err  out  1  frame error flag for the frame in rx_data.
REQ-019 rx_parity_err  out  1  parity error flag for the frame in rx_data.
REQ-020 rx_overrun  out  1  one-cycle pulse, frame dropped.

Function
REQ-021 SHALL run a free-running tick counter 0..baud_div; tick=1 for one cycle when counter>=baud_div, then counter returns to 0; baud_div=0 gives a tick every cycle.
REQ-022 Bit time SHALL be exactly OVERSAMPLE ticks for both TX and RX.
REQ-023 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-024 Accept occurs when tx_valid&&tx_ready; tx_data, parity_en, parity_odd and two_stop are latched; txd=0 from the next cycle.
REQ-025 TX SHALL send, LSB first: start (0), DATA_BITS data, parity (if latched parity_en), 1 or 2 stop bits (1).
REQ-026 Parity bit = XOR of data bits, inverted when parity_odd=1.
REQ-027 TX returns to IDLE after the last stop bit's OVERSAMPLE ticks; back-to-back frames with no idle gap beyond one PCLK cycle.
REQ-028 Config changes mid-frame SHALL NOT affect the frame in flight.
REQ-029 rxd SHALL pass a 2-flop synchroniser, reset value 1; RX logic uses the synchronised value only.
REQ-030 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-031 IDLE->START on synchronised rxd=0; after OVERSAMPLE/2 ticks sample: 0 -> DATA, 1 -> IDLE (glitch rejected, no flags).
REQ-032 DATA/PARITY/STOP samples SHALL be taken every OVERSAMPLE ticks after the start-bit centre; data shifted in LSB first.
REQ-033 Only one stop bit is checked at RX regardless of two_stop; stop sample 0 sets the frame error and goes to WAIT_HIGH, which exits to IDLE when rxd=1; stop=1 -> IDLE.
REQ-034 At the stop sample, the frame SHALL be delivered: rx_data, rx_frame_err and rx_parity_err loaded, rx_valid set, in the same cycle.
REQ-035 rx_valid clears on the cycle rx_valid&&rx_ready; flags hold until the next delivery.
REQ-036 If rx_valid=1 and rx_ready=0 at delivery, the new frame SHALL be dropped, rx_data unchanged, rx_overrun pulses 1 cycle.
REQ-037 Delivery and rx_ready in the same cycle with rx_valid=1: old frame consumed, new frame loaded, rx_valid stays 1, no overrun.
REQ-038 TX and RX SHALL be fully independent (full duplex, txd looped to rxd works).

Reset
REQ-039 PRESETn=0 SHALL immediately force: txd=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, rx_overrun=0, FSMs IDLE, tick counter 0, synchroniser to 1.
REQ-040 Reset mid-frame SHALL abort it; no partial frame is delivered after release.

Verification
REQ-041 DATA_BITS=8, baud_div=0, OVERSAMPLE=16, tx 0xA5 no parity -> txd 0,1,0,1,0,0,1,0,1,1 each 16 cycles; tx_ready low 160 cycles.
REQ-042 txd looped to rxd, parity_en=1, parity_odd=1, send 0x3C -> rx_data=0x3C, rx_valid=1, both error flags 0.
REQ-043 Drive rxd low 4 ticks then high -> no rx_valid, RX back to IDLE; then a stop bit forced 0 on 0x55 -> rx_frame_err=1, rx_valid=1, and RX waits until rxd=1.
REQ-044 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, rx_overrun single pulse; parity-corrupted frame -> rx_parity_err=1.
REQ-045 Assert PRESETn=0 mid-DATA of TX and RX -> txd=1, tx_ready=1 asynchronously; no rx_valid after release.
